req_gnt_responder: RTL and testbench

- Grant-side responder of the team's req/gnt handshake.
- The requester raises req with an ID; this block waits a fixed LATENCY cycles, then returns a one-cycle gnt carrying that ID.
- It then waits for req to drop before it accepts a new request.
- It keeps wrap-around grant and abort counters for bench visibility.
- Sits between a requester model and the checker benches in the assertion experiments.

---
 rtl/req_gnt_responder.sv | 173 +++++++++++++++++
 tb/tb_req_gnt_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/req_gnt_responder.sv
// ============================================================================
// Module   : req_gnt_responder
// Function : Grant side of the req/gnt handshake with fixed-latency grant,
//            withdrawal detection and wrap-around grant/abort counters.
//            Optional macro RESP_ASSERT_EN compiles in protocol checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module req_gnt_responder #(
    parameter int LATENCY = 9,
    parameter int CNT_W   = 4,
    parameter int ID_W    = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             req,
    input  logic [ID_W-1:0]  req_id,
    output logic             gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic             abort,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LATENCY - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_id_nxt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  w_gnt_id_nxt;
    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0] r_grant_cnt;
    logic [CNT_W-1:0] w_grant_cnt_nxt;
    logic [CNT_W-1:0] r_abort_cnt;
    logic [CNT_W-1:0] w_abort_cnt_nxt;
    logic             r_gnt;
    logic             w_gnt_nxt;
    logic             r_abort;
    logic             w_abort_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_id_nxt        = r_id;
        w_gnt_id_nxt    = r_gnt_id;
        w_wait_nxt      = r_wait;
        w_grant_cnt_nxt = r_grant_cnt;
        w_abort_cnt_nxt = r_abort_cnt;
        w_gnt_nxt       = 1'b0;
        w_abort_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = '0;
                    w_id_nxt    = req_id;
                end
            end
            S_WAIT: begin
                // Withdrawal beats an expiring wait count.
                if (!req) begin
                    w_abort_nxt     = 1'b1;
                    w_abort_cnt_nxt = r_abort_cnt + CNT_W'(1);
                    w_wait_nxt      = '0;
                    w_state_nxt     = S_IDLE;
                end else if (r_wait == c_LAST) begin
                    w_gnt_nxt       = 1'b1;
                    w_gnt_id_nxt    = r_id;
                    w_grant_cnt_nxt = r_grant_cnt + CNT_W'(1);
                    w_state_nxt     = S_GRANT;
                end else begin
                    w_wait_nxt = r_wait + CNT_W'(1);
                end
            end
            S_GRANT: begin
                w_wait_nxt  = '0;
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_gnt_id    <= '0;
            r_wait      <= '0;
            r_grant_cnt <= '0;
            r_abort_cnt <= '0;
            r_gnt       <= 1'b0;
            r_abort     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_id        <= w_id_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_wait      <= w_wait_nxt;
            r_grant_cnt <= w_grant_cnt_nxt;
            r_abort_cnt <= w_abort_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_abort     <= w_abort_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

`ifdef RESP_ASSERT_EN
    logic r_proto_err;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_proto_err <= 1'b0;
        end else begin
            CHK_GNT_ONE_HOT: assert (!(r_gnt && w_gnt_nxt))
                else begin
                    $error("CHK_GNT_ONE_HOT t=%0t state=%0d", $time, r_state);
                    r_proto_err <= 1'b1;
                end
            CHK_GNT_HAS_REQ: assert (!w_gnt_nxt || req)
                else begin
                    $error("CHK_GNT_HAS_REQ t=%0t state=%0d", $time, r_state);
                    r_proto_err <= 1'b1;
                end
            CHK_WAIT_RANGE: assert ((r_state != S_WAIT) || (r_wait <= c_LAST))
                else begin
                    $error("CHK_WAIT_RANGE t=%0t state=%0d", $time, r_state);
                    r_proto_err <= 1'b1;
                end
            // Informational only: a drop in WAIT is a legal abort.
            CHK_REQ_HELD: assert ((r_state != S_WAIT) || req)
                else $warning("CHK_REQ_HELD t=%0t state=%0d", $time, r_state);
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign busy      = r_busy;
    assign wait_cnt  = r_wait;
    assign grant_cnt = r_grant_cnt;
    assign abort_cnt = r_abort_cnt;
    assign abort     = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_req_gnt_responder.sv
// ============================================================================
// Module   : tb_req_gnt_responder
// Function : Directed bench for req_gnt_responder (LATENCY=9 and LATENCY=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_req_gnt_responder;

    localparam int LAT = 9;

    logic       clk;
    logic       RST;
    logic       req;
    logic [3:0] req_id;
    logic       gnt;
    logic [3:0] gnt_id;
    logic       busy;
    logic [3:0] wait_cnt;
    logic [3:0] grant_cnt;
    logic [3:0] abort_cnt;
    logic       abort;
    logic       proto_err;

    logic       req1;
    logic [3:0] req_id1;
    logic       gnt1;
    logic [3:0] gnt_id1;
    logic       busy1;
    logic [3:0] wait_cnt1;
    logic [3:0] grant_cnt1;
    logic [3:0] abort_cnt1;
    logic       abort1;
    logic       proto_err1;

    req_gnt_responder #(.LATENCY(LAT), .CNT_W(4), .ID_W(4)) u_dut (
        .clk(clk), .RST(RST), .req(req), .req_id(req_id),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .wait_cnt(wait_cnt),
        .grant_cnt(grant_cnt), .abort_cnt(abort_cnt), .abort(abort),
        .proto_err(proto_err)
    );

    req_gnt_responder #(.LATENCY(1), .CNT_W(4), .ID_W(4)) u_dut_l1 (
        .clk(clk), .RST(RST), .req(req1), .req_id(req_id1),
        .gnt(gnt1), .gnt_id(gnt_id1), .busy(busy1), .wait_cnt(wait_cnt1),
        .grant_cnt(grant_cnt1), .abort_cnt(abort_cnt1), .abort(abort1),
        .proto_err(proto_err1)
    );

    typedef struct {
        logic [3:0] id;
        int         gnt_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   exp_grants = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise req; if a grant is expected, book its ID and the edge it must appear after.
    task automatic raise(input logic [3:0] id, input bit granted);
        req    = 1'b1;
        req_id = id;
        if (granted) begin
            exp_q.push_back('{id: id, gnt_cyc: cyc + 1 + LAT});
            exp_grants++;
        end
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        cyc++;
        #1;
        if (gnt === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("gnt_spurious", 32'(gnt), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_gnt_id", 32'(gnt_id), 32'(e.id));
                check("sb_gnt_latency", 32'(cyc), 32'(e.gnt_cyc));
            end
        end
    end

    initial begin
        RST     = 1'b1;
        req     = 1'b1;
        req_id  = 4'h5;
        req1    = 1'b1;
        req_id1 = 4'h5;
        step(3);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wait_cnt", 32'(wait_cnt), 32'd0);
        check("rst_grant_cnt", 32'(grant_cnt), 32'd0);
        check("rst_abort_cnt", 32'(abort_cnt), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_l1_busy", 32'(busy1), 32'd0);

        // Request held through reset is accepted on the first edge after RST falls.
        req1 = 1'b0;
        RST  = 1'b0;
        raise(4'h5, 1'b1);
        step(1);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_wait_cnt", 32'(wait_cnt), 32'd0);
        step(9);
        check("first_gnt", 32'(gnt), 32'd1);
        check("first_grant_cnt", 32'(grant_cnt), 32'd1);
        req = 1'b0;
        step(2);
        check("first_idle_busy", 32'(busy), 32'd0);

        // Basic grant with ID A
        raise(4'hA, 1'b1);
        step(9);
        check("basic_pre_gnt", 32'(gnt), 32'd0);
        check("basic_wait_cnt_last", 32'(wait_cnt), 32'd8);
        step(1);
        check("basic_gnt", 32'(gnt), 32'd1);
        check("basic_gnt_id", 32'(gnt_id), 32'hA);
        check("basic_grant_cnt", 32'(grant_cnt), 32'(exp_grants));
        step(1);
        check("basic_gnt_low", 32'(gnt), 32'd0);
        check("basic_release_wait", 32'(wait_cnt), 32'd0);
        check("basic_release_busy", 32'(busy), 32'd1);
        check("basic_gnt_id_hold", 32'(gnt_id), 32'hA);
        req = 1'b0;
        step(1);
        check("basic_busy_drop", 32'(busy), 32'd0);

        // Abort sampled at E5
        raise(4'h6, 1'b0);
        step(5);
        req = 1'b0;
        step(1);
        check("abort5_pulse", 32'(abort), 32'd1);
        check("abort5_cnt", 32'(abort_cnt), 32'd1);
        check("abort5_busy", 32'(busy), 32'd0);
        check("abort5_wait_cnt", 32'(wait_cnt), 32'd0);
        check("abort5_gnt", 32'(gnt), 32'd0);
        step(1);
        check("abort5_pulse_end", 32'(abort), 32'd0);

        // Abort sampled exactly at the would-be granting edge
        raise(4'h7, 1'b0);
        step(9);
        req = 1'b0;
        step(1);
        check("abort9_pulse", 32'(abort), 32'd1);
        check("abort9_cnt", 32'(abort_cnt), 32'd2);
        check("abort9_gnt", 32'(gnt), 32'd0);
        check("abort9_grant_cnt", 32'(grant_cnt), 32'(exp_grants));
        step(1);

        // Back-to-back requests, req_id disturbed during WAIT
        for (int i = 1; i <= 3; i++) begin
            raise(4'(i), 1'b1);
            step(3);
            req_id = ~4'(i);
            step(7);
            check("b2b_gnt", 32'(gnt), 32'd1);
            check("b2b_gnt_id", 32'(gnt_id), 32'(i));
            step(1);
            req = 1'b0;
            step(1);
        end

        // Grant counter wrap after 17 grants
        while (exp_grants < 17) begin
            raise(4'(exp_grants), 1'b1);
            step(11);
            req = 1'b0;
            step(1);
        end
        check("wrap_grant_cnt", 32'(grant_cnt), 32'(exp_grants % 16));

        // Reset in the middle of WAIT
        raise(4'h7, 1'b1);
        step(6);
        check("midrst_wait_cnt_pre", 32'(wait_cnt), 32'd5);
        RST = 1'b1;
        exp_q.delete();
        exp_grants = 0;
        step(1);
        check("midrst_wait_cnt", 32'(wait_cnt), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_grant_cnt", 32'(grant_cnt), 32'd0);
        check("midrst_abort_cnt", 32'(abort_cnt), 32'd0);
        check("midrst_abort", 32'(abort), 32'd0);
        RST = 1'b0;
        req = 1'b0;
        step(12);
        check("midrst_after_grant_cnt", 32'(grant_cnt), 32'd0);

        // LATENCY=1 instance: grant one edge after acceptance
        req1    = 1'b1;
        req_id1 = 4'h3;
        step(1);
        check("l1_busy", 32'(busy1), 32'd1);
        check("l1_no_gnt_e0", 32'(gnt1), 32'd0);
        step(1);
        check("l1_gnt_e1", 32'(gnt1), 32'd1);
        check("l1_gnt_id", 32'(gnt_id1), 32'h3);
        check("l1_grant_cnt", 32'(grant_cnt1), 32'd1);
        step(1);
        check("l1_gnt_low", 32'(gnt1), 32'd0);
        req1 = 1'b0;
        step(1);
        check("l1_busy_drop", 32'(busy1), 32'd0);

        // LATENCY=1 abort at the granting edge
        req1 = 1'b1;
        step(1);
        req1 = 1'b0;
        step(1);
        check("l1_abort_pulse", 32'(abort1), 32'd1);
        check("l1_abort_gnt", 32'(gnt1), 32'd0);
        check("l1_abort_cnt", 32'(abort_cnt1), 32'd1);
        step(2);

        check("final_proto_err", 32'(proto_err), 32'd0);
        check("final_l1_proto_err", 32'(proto_err1), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
